regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the datapath: N read ports, two write ports, write-to-read bypass and a per-register pending (scoreboard) bit that tracks in-flight destinations. The highest-numbered register is not stored; it reads an externally supplied value (the PC). The block is the drop-in successor to the single-write, two-read register file. The scoreboard lets the controller stall on read-after-write hazards when the datapath is pipelined or multi-cycle.

---
 rtl/regfile_scoreboard.sv | 104 ++++++++++
 tb/tb_regfile_scoreboard.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two write ports, NRD combinational read ports, write-to-read bypass,
// an externally supplied top register (PC) and a per-register pending bit for hazard stalls.
module regfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int NRD    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_0,
  input  logic [ADDR_W-1:0]       wa_0,
  input  logic [WIDTH-1:0]        wd_0,
  input  logic                    we_1,
  input  logic [ADDR_W-1:0]       wa_1,
  input  logic [WIDTH-1:0]        wd_1,
  input  logic [NRD*ADDR_W-1:0]   ra,
  output logic [NRD*WIDTH-1:0]    rd,
  output logic [NRD-1:0]          rbusy,
  input  logic [WIDTH-1:0]        Reg_TOP,
  input  logic                    iss_valid,
  input  logic [ADDR_W-1:0]       iss_dest,
  output logic [(1<<ADDR_W)-1:0]  busy_vec
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(NREG - 1);

  logic [WIDTH-1:0] regs_r [0:NREG-2];
  logic [NREG-1:0]  busy_r;
  logic [NREG-1:0]  busy_next_s;
  logic             wr0_s;
  logic             wr1_s;
  logic             iss_s;

  assign wr0_s    = we_0 && (wa_0 != TOP);
  assign wr1_s    = we_1 && (wa_1 != TOP);
  assign iss_s    = iss_valid && (iss_dest != TOP);
  assign busy_vec = busy_r;

  // Next pending bits: writes retire a producer, an issue in the same cycle re-arms it.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < NREG - 1; i++) begin
      if ((wr0_s && (wa_0 == ADDR_W'(i))) || (wr1_s && (wa_1 == ADDR_W'(i)))) begin
        busy_next_s[i] = 1'b0;
      end else begin
        busy_next_s[i] = busy_r[i];
      end
      if (iss_s && (iss_dest == ADDR_W'(i))) begin
        busy_next_s[i] = 1'b1;
      end else begin
        busy_next_s[i] = busy_next_s[i];
      end
    end
    busy_next_s[NREG-1] = 1'b0;
  end

  // Register storage and scoreboard state; port 1 wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
      busy_r <= {NREG{1'b0}};
    end else begin
      for (int i = 0; i < NREG - 1; i++) begin
        if (wr1_s && (wa_1 == ADDR_W'(i))) begin
          regs_r[i] <= wd_1;
        end else if (wr0_s && (wa_0 == ADDR_W'(i))) begin
          regs_r[i] <= wd_0;
        end
      end
      busy_r <= busy_next_s;
    end
  end

  // Combinational read ports with bypass; a bypassed operand is never reported busy.
  always_comb begin
    logic [ADDR_W-1:0] addr_s;
    logic [WIDTH-1:0]  stored_s;
    rd    = {(NRD*WIDTH){1'b0}};
    rbusy = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      addr_s   = ra[k*ADDR_W +: ADDR_W];
      stored_s = {WIDTH{1'b0}};
      for (int i = 0; i < NREG - 1; i++) begin
        stored_s = (addr_s == ADDR_W'(i)) ? regs_r[i] : stored_s;
      end
      if (addr_s == TOP) begin
        rd[k*WIDTH +: WIDTH] = Reg_TOP;
      end else if (we_1 && (wa_1 == addr_s)) begin
        rd[k*WIDTH +: WIDTH] = wd_1;
      end else if (we_0 && (wa_0 == addr_s)) begin
        rd[k*WIDTH +: WIDTH] = wd_0;
      end else begin
        rd[k*WIDTH +: WIDTH] = stored_s;
      end
      rbusy[k] = busy_r[addr_s] && (addr_s != TOP)
                 && !(wr0_s && (wa_0 == addr_s))
                 && !(wr1_s && (wa_1 == addr_s));
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations (ADDR_W=4, NRD=2).
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_0, we_1;
  logic [3:0]  wa_0, wa_1;
  logic [31:0] wd_0, wd_1;
  logic [7:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic [31:0] Reg_TOP;
  logic        iss_valid;
  logic [3:0]  iss_dest;
  logic [15:0] busy_vec;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_scoreboard #(.WIDTH(32), .ADDR_W(4), .NRD(2)) dut (
    .clk(clk), .reset(reset),
    .we_0(we_0), .wa_0(wa_0), .wd_0(wd_0),
    .we_1(we_1), .wa_1(wa_1), .wd_1(wd_1),
    .ra(ra), .rd(rd), .rbusy(rbusy), .Reg_TOP(Reg_TOP),
    .iss_valid(iss_valid), .iss_dest(iss_dest), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and step 1 time unit past it before driving new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_0 = 1'b0; we_1 = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic set_ra(input logic [3:0] a0, input logic [3:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    reset = 1'b1; idle();
    wa_0 = 4'd0; wa_1 = 4'd0; wd_0 = 32'd0; wd_1 = 32'd0;
    iss_dest = 4'd0; Reg_TOP = 32'd0; set_ra(4'd0, 4'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("reset_busy", busy_vec, 64'h0);
    check_eq("reset_rd0", rd[31:0], 64'h0);

    // Write R3 on port 0; bypass in the same cycle, storage afterwards.
    we_0 = 1'b1; wa_0 = 4'd3; wd_0 = 32'hDEADBEEF; set_ra(4'd0, 4'd3);
    #1;
    check_eq("bypass_p0", rd[63:32], 64'hDEADBEEF);
    tick(); idle(); set_ra(4'd3, 4'd4);
    #1;
    check_eq("stored_r3", rd[31:0], 64'hDEADBEEF);
    check_eq("stored_r4", rd[63:32], 64'h0);

    // Collision on R5: port 1 wins, both in bypass and in storage.
    we_0 = 1'b1; wa_0 = 4'd5; wd_0 = 32'h11;
    we_1 = 1'b1; wa_1 = 4'd5; wd_1 = 32'h22; set_ra(4'd5, 4'd3);
    #1;
    check_eq("collide_bypass", rd[31:0], 64'h22);
    tick(); idle();
    #1;
    check_eq("collide_stored", rd[31:0], 64'h22);
    check_eq("no_spurious_busy", busy_vec, 64'h0);

    // TOP reads the external value; writes and issues to TOP are ignored.
    Reg_TOP = 32'h100; we_0 = 1'b1; wa_0 = 4'd15; wd_0 = 32'hFFFF;
    iss_valid = 1'b1; iss_dest = 4'd15; set_ra(4'd15, 4'd5);
    #1;
    check_eq("top_before", rd[31:0], 64'h100);
    check_eq("top_rbusy", rbusy, 64'h0);
    tick(); idle();
    #1;
    check_eq("top_after", rd[31:0], 64'h100);
    check_eq("top_issue_busy", busy_vec, 64'h0);

    // Scoreboard lifecycle on R7.
    iss_valid = 1'b1; iss_dest = 4'd7; set_ra(4'd7, 4'd5);
    tick(); idle();
    #1;
    check_eq("r7_busy_vec", busy_vec, 64'h0080);
    for (int c = 0; c < 3; c++) begin
      check_eq("r7_rbusy_hold", rbusy, 64'h1);
      tick();
    end
    we_1 = 1'b1; wa_1 = 4'd7; wd_1 = 32'h55;
    #1;
    check_eq("r7_rbusy_wr", rbusy, 64'h0);
    check_eq("r7_rd_wr", rd[31:0], 64'h55);
    check_eq("r7_busy_pre", busy_vec, 64'h0080);
    tick(); idle();
    #1;
    check_eq("r7_busy_post", busy_vec, 64'h0);
    check_eq("r7_stored", rd[31:0], 64'h55);

    // Set/clear race on R2: issue wins over the retiring write.
    iss_valid = 1'b1; iss_dest = 4'd2; set_ra(4'd2, 4'd7);
    tick(); idle();
    #1;
    check_eq("r2_busy", busy_vec, 64'h0004);
    we_0 = 1'b1; wa_0 = 4'd2; wd_0 = 32'h77; iss_valid = 1'b1; iss_dest = 4'd2;
    tick(); idle();
    #1;
    check_eq("race_busy", busy_vec, 64'h0004);
    check_eq("race_data", rd[31:0], 64'h77);
    check_eq("race_rbusy", rbusy, 64'h1);

    // Reset mid-flight: R1..R4 hold data and are pending.
    for (int i = 1; i <= 4; i++) begin
      we_0 = 1'b1; wa_0 = 4'(i); wd_0 = 32'hA0 + 32'(i);
      tick();
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      iss_valid = 1'b1; iss_dest = 4'(i);
      tick();
    end
    idle(); set_ra(4'd4, 4'd1);
    #1;
    check_eq("pre_reset_busy", busy_vec, 64'h001E);
    check_eq("pre_reset_r4", rd[31:0], 64'hA4);
    check_eq("pre_reset_r1", rd[63:32], 64'hA1);
    reset = 1'b1;
    we_1 = 1'b1; wa_1 = 4'd6; wd_1 = 32'h99; iss_valid = 1'b1; iss_dest = 4'd6;
    tick();
    reset = 1'b0; idle();
    #1;
    check_eq("post_reset_busy", busy_vec, 64'h0);
    for (int i = 0; i < 15; i++) begin
      set_ra(4'(i), 4'(14 - i));
      #1;
      check_eq("post_reset_rd0", rd[31:0], 64'h0);
      check_eq("post_reset_rd1", rd[63:32], 64'h0);
      check_eq("post_reset_rbusy", rbusy, 64'h0);
    end
    set_ra(4'd15, 4'd0);
    #1;
    check_eq("post_reset_top", rd[31:0], 64'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
